// File: rtl/div_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer_if
// Brief    : Request/result and datapath-control bundle for div_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface div_sequencer_if #(
    parameter int p_N     = 16,
    parameter int p_CNT_W = 16
);
    logic               i_start;
    logic [p_N-1:0]     i_dividend;
    logic [p_N-1:0]     i_divisor;
    logic               mayor;
    logic [8:0]         o_signal;
    logic               o_ext_sel;
    logic [p_N-1:0]     o_ext_data;
    logic               o_busy;
    logic               o_done;
    logic               o_err;
    logic [p_CNT_W-1:0] o_iter;

    // Sequencer side
    modport slave (
        input  i_start, i_dividend, i_divisor, mayor,
        output o_signal, o_ext_sel, o_ext_data, o_busy, o_done, o_err, o_iter
    );

    // Requester / datapath side
    modport master (
        output i_start, i_dividend, i_divisor, mayor,
        input  o_signal, o_ext_sel, o_ext_data, o_busy, o_done, o_err, o_iter
    );
endinterface
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Brief    : Start/done controller sequencing unsigned division by repeated
//            subtraction on the 4-register / 2-mux / ALU datapath.
// Revision : 1.0 - initial release
// ============================================================================
module div_sequencer #(
    parameter int p_N        = 16,
    parameter int p_MAX_ITER = 65535,
    parameter int p_CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    div_sequencer_if.slave bus
);

    // ALU operation encodings
    localparam logic [1:0] c_OP_ADD  = 2'b00;
    localparam logic [1:0] c_OP_SUB  = 2'b01;
    localparam logic [1:0] c_OP_ZERO = 2'b11;

    // Register / mux select encodings
    localparam logic [1:0] c_R1 = 2'b00;
    localparam logic [1:0] c_R2 = 2'b01;
    localparam logic [1:0] c_R3 = 2'b10;
    localparam logic [1:0] c_R4 = 2'b11;

    localparam logic [p_CNT_W-1:0] c_MAX_ITER = p_CNT_W'(p_MAX_ITER);
    localparam logic [p_N-1:0]     c_ONE      = p_N'(1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LD_A   = 4'd1,
        S_LD_B   = 4'd2,
        S_CLR_Q  = 4'd3,
        S_LD_ONE = 4'd4,
        S_CMP    = 4'd5,
        S_SUB    = 4'd6,
        S_INC    = 4'd7,
        S_DONE   = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [p_N-1:0]     r_dividend;
    logic [p_N-1:0]     r_divisor;
    logic [p_CNT_W-1:0] r_iter;

    logic [1:0]         w_alu_op;
    logic [1:0]         w_sel_a;
    logic [1:0]         w_sel_b;
    logic [1:0]         w_dest;
    logic               w_we;
    logic               w_ext_sel;
    logic [p_N-1:0]     w_ext_data;
    logic               w_busy;
    logic               w_done;
    logic               w_err;
    logic               w_accept;

    assign w_accept = (r_state == S_IDLE) && bus.i_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_iter     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dividend <= bus.i_dividend;
                r_divisor  <= bus.i_divisor;
                r_iter     <= '0;
            end else if (r_state == S_INC) begin
                r_iter <= r_iter + p_CNT_W'(1);
            end
        end
    end

    // Outputs depend on r_state and captured operands only; mayor and
    // i_start steer the next state but never reach an output directly.
    always_comb begin
        w_state_nxt = r_state;
        w_alu_op    = c_OP_ADD;
        w_sel_a     = c_R1;
        w_sel_b     = c_R1;
        w_dest      = c_R1;
        w_we        = 1'b0;
        w_ext_sel   = 1'b0;
        w_ext_data  = '0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = (bus.i_divisor == '0) ? S_ERR : S_LD_A;
                end
            end
            S_LD_A: begin
                w_busy      = 1'b1;
                w_ext_sel   = 1'b1;
                w_ext_data  = r_dividend;
                w_dest      = c_R1;
                w_we        = 1'b1;
                w_state_nxt = S_LD_B;
            end
            S_LD_B: begin
                w_busy      = 1'b1;
                w_ext_sel   = 1'b1;
                w_ext_data  = r_divisor;
                w_dest      = c_R2;
                w_we        = 1'b1;
                w_state_nxt = S_CLR_Q;
            end
            S_CLR_Q: begin
                w_busy      = 1'b1;
                w_alu_op    = c_OP_ZERO;
                w_dest      = c_R3;
                w_we        = 1'b1;
                w_state_nxt = S_LD_ONE;
            end
            S_LD_ONE: begin
                w_busy      = 1'b1;
                w_ext_sel   = 1'b1;
                w_ext_data  = c_ONE;
                w_dest      = c_R4;
                w_we        = 1'b1;
                w_state_nxt = S_CMP;
            end
            S_CMP: begin
                // mayor reflects r1 >= r2 for this control word
                w_busy   = 1'b1;
                w_alu_op = c_OP_SUB;
                w_sel_a  = c_R1;
                w_sel_b  = c_R2;
                if (bus.mayor && (r_iter == c_MAX_ITER)) begin
                    w_state_nxt = S_ERR;
                end else if (bus.mayor) begin
                    w_state_nxt = S_SUB;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_SUB: begin
                w_busy      = 1'b1;
                w_alu_op    = c_OP_SUB;
                w_sel_a     = c_R1;
                w_sel_b     = c_R2;
                w_dest      = c_R1;
                w_we        = 1'b1;
                w_state_nxt = S_INC;
            end
            S_INC: begin
                w_busy      = 1'b1;
                w_alu_op    = c_OP_ADD;
                w_sel_a     = c_R3;
                w_sel_b     = c_R4;
                w_dest      = c_R3;
                w_we        = 1'b1;
                w_state_nxt = S_CMP;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                w_done      = 1'b1;
                w_err       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.o_signal   = {w_alu_op, w_sel_a, w_sel_b, w_dest, w_we};
    assign bus.o_ext_sel  = w_ext_sel;
    assign bus.o_ext_data = w_ext_data;
    assign bus.o_busy     = w_busy;
    assign bus.o_done     = w_done;
    assign bus.o_err      = w_err;
    assign bus.o_iter     = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sequencer
// Brief    : Directed bench for div_sequencer driving a behavioural datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    bit   use_lim;

    div_sequencer_if #(.p_N(16), .p_CNT_W(16)) bus ();
    div_sequencer_if #(.p_N(16), .p_CNT_W(16)) bus_lim ();

    div_sequencer #(.p_N(16), .p_MAX_ITER(65535), .p_CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    div_sequencer #(.p_N(16), .p_MAX_ITER(3), .p_CNT_W(16)) dut_lim (
        .clk (clk),
        .rst (rst),
        .bus (bus_lim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: r1..r4, mux A/B, ALU, mayor = A >= B
    logic [15:0] rf [4];
    logic [15:0] a_v, b_v, alu_v;
    always_comb begin
        a_v = rf[bus.o_signal[6:5]];
        b_v = rf[bus.o_signal[4:3]];
        case (bus.o_signal[8:7])
            2'b00:   alu_v = a_v + b_v;
            2'b01:   alu_v = a_v - b_v;
            2'b10:   alu_v = a_v;
            default: alu_v = 16'd0;
        endcase
    end
    assign bus.mayor = (a_v >= b_v);
    always_ff @(posedge clk)
        if (bus.o_signal[0])
            rf[bus.o_signal[2:1]] <= bus.o_ext_sel ? bus.o_ext_data : alu_v;

    logic [15:0] rl [4];
    logic [15:0] la_v, lb_v, lalu_v;
    always_comb begin
        la_v = rl[bus_lim.o_signal[6:5]];
        lb_v = rl[bus_lim.o_signal[4:3]];
        case (bus_lim.o_signal[8:7])
            2'b00:   lalu_v = la_v + lb_v;
            2'b01:   lalu_v = la_v - lb_v;
            2'b10:   lalu_v = la_v;
            default: lalu_v = 16'd0;
        endcase
    end
    assign bus_lim.mayor = (la_v >= lb_v);
    always_ff @(posedge clk)
        if (bus_lim.o_signal[0])
            rl[bus_lim.o_signal[2:1]] <= bus_lim.o_ext_sel ? bus_lim.o_ext_data : lalu_v;

    // Observation of whichever instance the current step targets
    logic [8:0]  sig_s;
    logic        busy_s, done_s, err_s, ext_sel_s;
    logic [15:0] ext_data_s, iter_s;
    assign sig_s      = use_lim ? bus_lim.o_signal   : bus.o_signal;
    assign busy_s     = use_lim ? bus_lim.o_busy     : bus.o_busy;
    assign done_s     = use_lim ? bus_lim.o_done     : bus.o_done;
    assign err_s      = use_lim ? bus_lim.o_err      : bus.o_err;
    assign ext_sel_s  = use_lim ? bus_lim.o_ext_sel  : bus.o_ext_sel;
    assign ext_data_s = use_lim ? bus_lim.o_ext_data : bus.o_ext_data;
    assign iter_s     = use_lim ? bus_lim.o_iter     : bus.o_iter;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (use_lim) bus_lim.i_start = v;
        else         bus.i_start     = v;
    endtask

    // Called at a sample point; returns at the cycle o_done is seen
    // (cycle numbers count edges after the accepting edge).
    task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs, input bit hold,
                          input int budget, output int done_cyc, output int we_cnt,
                          output int sub_cnt, output int busy_cnt, output int sig_cnt);
        done_cyc = -1; we_cnt = 0; sub_cnt = 0; busy_cnt = 0; sig_cnt = 0;
        @(posedge clk); #1;
        bus.i_dividend = dvd;     bus.i_divisor = dvs;
        bus_lim.i_dividend = dvd; bus_lim.i_divisor = dvs;
        set_start(1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(1'b0);
        for (int k = 1; k <= budget; k++) begin
            we_cnt   += int'(sig_s[0]);
            sub_cnt  += int'(sig_s[0] && (sig_s[8:7] == 2'b01));
            busy_cnt += int'(busy_s);
            sig_cnt  += int'(sig_s != 9'd0);
            if (done_s) begin
                done_cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    int dc, we, sc, bc, gc;

    initial begin
        n_vec = 0; n_bad = 0; use_lim = 1'b0;
        rst = 1'b1;
        bus.i_start = 1'b0;     bus.i_dividend = 16'd0;     bus.i_divisor = 16'd0;
        bus_lim.i_start = 1'b0; bus_lim.i_dividend = 16'd0; bus_lim.i_divisor = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_signal",   32'(bus.o_signal),   32'd0);
        check("rst_ext_sel",  32'(bus.o_ext_sel),  32'd0);
        check("rst_ext_data", 32'(bus.o_ext_data), 32'd0);
        check("rst_busy",     32'(bus.o_busy),     32'd0);
        check("rst_done",     32'(bus.o_done),     32'd0);
        check("rst_err",      32'(bus.o_err),      32'd0);
        check("rst_iter",     32'(bus.o_iter),     32'd0);
        rst = 1'b0;

        // 100 / 7 = 14 r 2
        run_op(16'd100, 16'd7, 1'b0, 200, dc, we, sc, bc, gc);
        check("d100_done_cyc", 32'(dc),     32'd48);
        check("d100_err",      32'(err_s),  32'd0);
        check("d100_iter",     32'(iter_s), 32'd14);
        check("d100_r3",       32'(rf[2]),  32'd14);
        check("d100_r1",       32'(rf[0]),  32'd2);
        check("d100_we_cnt",   32'(we),     32'd32);
        check("d100_busy_cnt", 32'(bc),     32'd47);
        @(posedge clk); #1;
        check("d100_iter_hold", 32'(iter_s), 32'd14);
        check("d100_done_pulse", 32'(done_s), 32'd0);

        // 0 / 5: no iteration
        run_op(16'd0, 16'd5, 1'b0, 50, dc, we, sc, bc, gc);
        check("d0_done_cyc", 32'(dc),     32'd6);
        check("d0_iter",     32'(iter_s), 32'd0);
        check("d0_r3",       32'(rf[2]),  32'd0);
        check("d0_r1",       32'(rf[0]),  32'd0);
        check("d0_sub_cnt",  32'(sc),     32'd0);

        // 9 / 0: immediate error, datapath untouched
        run_op(16'd9, 16'd0, 1'b0, 20, dc, we, sc, bc, gc);
        check("z_done_cyc", 32'(dc),    32'd1);
        check("z_err",      32'(err_s), 32'd1);
        check("z_sig_cnt",  32'(gc),    32'd0);
        check("z_busy_cnt", 32'(bc),    32'd0);

        // Iteration limit of 3 with 20 / 2
        use_lim = 1'b1;
        run_op(16'd20, 16'd2, 1'b0, 100, dc, we, sc, bc, gc);
        check("lim_done_cyc", 32'(dc),     32'd15);
        check("lim_err",      32'(err_s),  32'd1);
        check("lim_iter",     32'(iter_s), 32'd3);
        check("lim_r3",       32'(rl[2]),  32'd3);
        check("lim_r1",       32'(rl[0]),  32'd14);
        use_lim = 1'b0;

        // 7 / 7 with i_start held high throughout
        run_op(16'd7, 16'd7, 1'b1, 50, dc, we, sc, bc, gc);
        check("hold_done_cyc", 32'(dc),     32'd9);
        check("hold_iter",     32'(iter_s), 32'd1);
        check("hold_r1",       32'(rf[0]),  32'd0);
        check("hold_busy_cnt", 32'(bc),     32'd8);
        @(posedge clk); #1;
        check("hold_idle_busy", 32'(busy_s), 32'd0);
        check("hold_idle_sig",  32'(sig_s),  32'd0);
        @(posedge clk); #1;
        check("hold_restart_busy", 32'(busy_s),     32'd1);
        check("hold_restart_sig",  32'(sig_s),      32'h001);
        check("hold_restart_data", 32'(ext_data_s), 32'd7);
        check("hold_restart_esel", 32'(ext_sel_s),  32'd1);
        bus.i_start = 1'b0;
        dc = -1;
        for (int k = 11; k <= 60; k++) begin
            if (done_s) begin
                dc = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("hold_second_done_cyc", 32'(dc), 32'd19);

        // Reset in the middle of 1000 / 3
        @(posedge clk); #1;
        bus.i_dividend = 16'd1000; bus.i_divisor = 16'd3; bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("mid_busy", 32'(bus.o_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_signal", 32'(bus.o_signal),   32'd0);
        check("mid_rst_busy",   32'(bus.o_busy),     32'd0);
        check("mid_rst_iter",   32'(bus.o_iter),     32'd0);
        check("mid_rst_esel",   32'(bus.o_ext_sel),  32'd0);
        check("mid_rst_edata",  32'(bus.o_ext_data), 32'd0);
        check("mid_rst_done",   32'(bus.o_done),     32'd0);
        rst = 1'b0;

        run_op(16'd6, 16'd3, 1'b0, 60, dc, we, sc, bc, gc);
        check("post_done_cyc", 32'(dc),     32'd12);
        check("post_iter",     32'(iter_s), 32'd2);
        check("post_r3",       32'(rf[2]),  32'd2);
        check("post_r1",       32'(rf[0]),  32'd0);
        check("post_err",      32'(err_s),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
